framebuffer_writer: RTL



---
 rtl/framebuffer_writer_pkg.sv | 22 ++
 rtl/framebuffer_writer_bank.sv | 25 ++
 rtl/framebuffer_writer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_writer_pkg.sv
// Shared types for the frame store: pixel colour, default frame size and FSM states.
package framebuffer_writer_pkg;

  localparam int unsigned PIXEL_X = 8;
  localparam int unsigned PIXEL_Y = 8;
  localparam int unsigned RGB_W   = 8;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } Color;

  typedef enum logic {WR_FILL, WR_WAIT} wr_state_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_writer_bank.sv
// One frame bank: register array with a synchronous write port and an asynchronous read port.
module framebuffer_writer_bank #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 24,
  parameter int unsigned AddrW = 6
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/framebuffer_writer.sv
// Double-buffered frame store: raster-order capture into the back bank, ready/valid scan-out
// of the front bank, swapping banks whenever a full frame meets an idle or finishing reader.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = PIXEL_X,
  parameter int unsigned PIXEL_HEIGHT = PIXEL_Y,
  parameter int unsigned RGB_WIDTH    = RGB_W,
  localparam int unsigned NPIX  = PIXEL_WIDTH * PIXEL_HEIGHT,
  localparam int unsigned IDX_W = clog2_min1(NPIX),
  localparam int unsigned X_W   = clog2_min1(PIXEL_WIDTH),
  localparam int unsigned Y_W   = clog2_min1(PIXEL_HEIGHT),
  localparam int unsigned C_W   = 3 * RGB_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_valid,
  input  logic [C_W-1:0] wr_color,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [C_W-1:0] rd_color,
  output logic [X_W-1:0] rd_x,
  output logic [Y_W-1:0] rd_y,
  output logic           rd_last,
  output logic           frame_done,
  output logic           overflow,
  output logic [15:0]    drop_count
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPIX - 1);
  localparam logic [X_W-1:0]   LastX   = X_W'(PIXEL_WIDTH - 1);

  wr_state_t        r_wr_state;
  rd_state_t        r_rd_state;
  logic             r_wb;
  logic [IDX_W-1:0] r_wi;
  logic [IDX_W-1:0] r_ri;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_frame_done;
  logic             r_overflow;
  logic [15:0]      r_drop_count;

  logic             w_wr_fill;
  logic             w_wr_last;
  logic             w_frame_ready;
  logic             w_rd_last_hs;
  logic             w_swap;
  logic [C_W-1:0]   w_rdata0;
  logic [C_W-1:0]   w_rdata1;
  logic [C_W-1:0]   w_front;

  assign w_wr_fill     = (r_wr_state == WR_FILL) && wr_valid;
  assign w_wr_last     = w_wr_fill && (r_wi == LastIdx);
  assign w_frame_ready = (r_wr_state == WR_WAIT) || w_wr_last;
  assign w_rd_last_hs  = (r_rd_state == RD_STREAM) && rd_ready && (r_ri == LastIdx);
  // A finishing reader hands its bank over in the same cycle, so back-to-back frames have no gap.
  assign w_swap        = w_frame_ready && ((r_rd_state == RD_IDLE) || w_rd_last_hs);

  framebuffer_writer_bank #(
    .Depth (NPIX),
    .Width (C_W),
    .AddrW (IDX_W)
  ) u_bank0 (
    .i_clk   (clk),
    .i_we    (w_wr_fill && !r_wb),
    .i_waddr (r_wi),
    .i_wdata (wr_color),
    .i_raddr (r_ri),
    .o_rdata (w_rdata0)
  );

  framebuffer_writer_bank #(
    .Depth (NPIX),
    .Width (C_W),
    .AddrW (IDX_W)
  ) u_bank1 (
    .i_clk   (clk),
    .i_we    (w_wr_fill && r_wb),
    .i_waddr (r_wi),
    .i_wdata (wr_color),
    .i_raddr (r_ri),
    .o_rdata (w_rdata1)
  );

  // Writer FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_state   <= WR_FILL;
      r_wb         <= 1'b0;
      r_wi         <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_wr_state)
        WR_FILL: begin
          if (wr_valid) begin
            if (r_wi == LastIdx) begin
              r_wi         <= '0;
              r_frame_done <= 1'b1;
              if (w_swap) begin
                r_wb <= ~r_wb;
              end else begin
                r_wr_state <= WR_WAIT;
              end
            end else begin
              r_wi <= r_wi + 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (wr_valid) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
              r_drop_count <= r_drop_count + 16'd1;
            end
          end
          if (w_swap) begin
            r_wb       <= ~r_wb;
            r_wr_state <= WR_FILL;
          end
        end
        default: r_wr_state <= WR_FILL;
      endcase
    end
  end

  // Reader FSM; x/y track ri in raster order so no divider is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_state <= RD_IDLE;
      r_ri       <= '0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      unique case (r_rd_state)
        RD_IDLE: begin
          if (w_swap) begin
            r_rd_state <= RD_STREAM;
            r_ri       <= '0;
            r_x        <= '0;
            r_y        <= '0;
          end
        end
        RD_STREAM: begin
          if (rd_ready) begin
            if (r_ri == LastIdx) begin
              r_ri <= '0;
              r_x  <= '0;
              r_y  <= '0;
              if (!w_swap) begin
                r_rd_state <= RD_IDLE;
              end
            end else begin
              r_ri <= r_ri + 1'b1;
              if (r_x == LastX) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign w_front    = r_wb ? w_rdata0 : w_rdata1;
  assign rd_valid   = (r_rd_state == RD_STREAM);
  assign rd_color   = rd_valid ? w_front : '0;
  assign rd_x       = r_x;
  assign rd_y       = r_y;
  assign rd_last    = rd_valid && (r_ri == LastIdx);
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
